// File: rtl/tl_a_pkg.sv
// tl_a_pkg: shared TileLink A-channel definitions for the A queue.
//   Opcode encodings, default field widths, the reference packed beat layout
//   and a helper returning the packed beat width for arbitrary field widths.
package tl_a_pkg;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;
    localparam logic [2:0] OP_ACQUIRE     = 3'd6;

    localparam int SOURCE_W_DEF = 5;
    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 64;
    localparam int SIZE_W_DEF   = 4;

    typedef struct packed {
        logic [2:0]              opcode;
        logic [2:0]              param;
        logic [SIZE_W_DEF-1:0]   size;
        logic [SOURCE_W_DEF-1:0] source;
        logic [ADDR_W_DEF-1:0]   address;
        logic [DATA_W_DEF-1:0]   data;
        logic                    corrupt;
    } tl_a_beat_t;

    // Packed beat width; the 7 covers opcode, param and corrupt.
    function automatic int tl_a_beat_w(input int size_w, input int source_w,
                                       input int addr_w, input int data_w);
        return 7 + size_w + source_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/tl_a_queue_ram.sv
// tl_a_queue_ram: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
//   clock   : write clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : read data (combinational)
module tl_a_queue_ram #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int AW    = 1
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tl_a_channel_queue.sv
// tl_a_channel_queue: parametrised FIFO for TileLink A-channel beats with optional FLOW/PIPE modes.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   io_enq_valid/ready     : producer handshake
//   io_enq_bits_*          : incoming beat (opcode/param/size/source/address/data/corrupt)
//   io_deq_valid/ready     : consumer handshake
//   io_deq_bits_*          : head beat
//   io_count               : occupancy derived from registered state
module tl_a_channel_queue
    import tl_a_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int SOURCE_W = SOURCE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SIZE_W   = SIZE_W_DEF,
    parameter int FLOW     = 0,
    parameter int PIPE     = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_enq_valid,
    output logic                       io_enq_ready,
    input  logic [2:0]                 io_enq_bits_opcode,
    input  logic [2:0]                 io_enq_bits_param,
    input  logic [SIZE_W-1:0]          io_enq_bits_size,
    input  logic [SOURCE_W-1:0]        io_enq_bits_source,
    input  logic [ADDR_W-1:0]          io_enq_bits_address,
    input  logic [DATA_W-1:0]          io_enq_bits_data,
    input  logic                       io_enq_bits_corrupt,
    output logic                       io_deq_valid,
    input  logic                       io_deq_ready,
    output logic [2:0]                 io_deq_bits_opcode,
    output logic [2:0]                 io_deq_bits_param,
    output logic [SIZE_W-1:0]          io_deq_bits_size,
    output logic [SOURCE_W-1:0]        io_deq_bits_source,
    output logic [ADDR_W-1:0]          io_deq_bits_address,
    output logic [DATA_W-1:0]          io_deq_bits_data,
    output logic                       io_deq_bits_corrupt,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = tl_a_beat_w(SIZE_W, SOURCE_W, ADDR_W, DATA_W);

    logic [PW-1:0] r_enq_ptr, r_deq_ptr;
    logic          r_maybe_full;

    logic          w_match, w_empty, w_full, w_flow_empty, w_bypass;
    logic          w_do_enq, w_do_deq, w_enq_eff, w_deq_eff;
    logic [BW-1:0] w_enq_beat, w_head, w_deq_beat;
    logic [CW-1:0] w_diff;

    assign w_match      = r_enq_ptr == r_deq_ptr;
    assign w_empty      = w_match & ~r_maybe_full;
    assign w_full       = w_match & r_maybe_full;
    assign w_flow_empty = (FLOW != 0) & w_empty;

    assign io_deq_valid = ~w_empty | (w_flow_empty & io_enq_valid);
    assign io_enq_ready = ~w_full | ((PIPE != 0) & io_deq_ready);

    assign w_do_enq = io_enq_valid & io_enq_ready;
    assign w_do_deq = io_deq_valid & io_deq_ready;

    // A flow-through beat never touches storage, pointers or maybe_full.
    assign w_bypass  = w_flow_empty & io_deq_ready;
    assign w_enq_eff = w_do_enq & ~w_bypass;
    assign w_deq_eff = w_do_deq & ~w_bypass;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_enq_eff) r_enq_ptr <= r_enq_ptr == PW'(DEPTH - 1) ? '0 : r_enq_ptr + 1'b1;
            if (w_deq_eff) r_deq_ptr <= r_deq_ptr == PW'(DEPTH - 1) ? '0 : r_deq_ptr + 1'b1;
            if (w_enq_eff != w_deq_eff) r_maybe_full <= w_enq_eff;
        end
    end

    assign w_enq_beat = {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size, io_enq_bits_source,
                         io_enq_bits_address, io_enq_bits_data, io_enq_bits_corrupt};

    tl_a_queue_ram #(.DEPTH(DEPTH), .WIDTH(BW), .AW(PW)) u_ram (
        .clock   (clock),
        .i_we    (w_enq_eff),
        .i_waddr (r_enq_ptr),
        .i_wdata (w_enq_beat),
        .i_raddr (r_deq_ptr),
        .o_rdata (w_head)
    );

    assign w_deq_beat = w_flow_empty ? w_enq_beat : w_head;
    assign {io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size, io_deq_bits_source,
            io_deq_bits_address, io_deq_bits_data, io_deq_bits_corrupt} = w_deq_beat;

    // Pointer distance modulo DEPTH; full is the one case where it reads 0 but means DEPTH.
    assign w_diff   = r_enq_ptr >= r_deq_ptr ? CW'(r_enq_ptr) - CW'(r_deq_ptr)
                                             : CW'(DEPTH) + CW'(r_enq_ptr) - CW'(r_deq_ptr);
    assign io_count = w_full ? CW'(DEPTH) : w_diff;

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// tb_tl_a_channel_queue: scoreboard bench over four queue configurations
//   (0: DEPTH=2, 1: DEPTH=3, 2: DEPTH=2 FLOW, 3: DEPTH=2 PIPE).
module tb_tl_a_channel_queue;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  opcode, param;
    logic [3:0]  size;
    logic [4:0]  source;
    logic [31:0] address;
    logic [63:0] data;
    logic        corrupt;

    logic        enq_valid [4];
    logic        enq_ready [4];
    logic        deq_valid [4];
    logic        deq_ready [4];
    logic [2:0]  deq_opcode [4];
    logic [2:0]  deq_param [4];
    logic [3:0]  deq_size [4];
    logic [4:0]  deq_source [4];
    logic [31:0] deq_address [4];
    logic [63:0] deq_data [4];
    logic        deq_corrupt [4];
    logic [1:0]  count [4];

    int n_checks = 0;
    int n_fails  = 0;
    int pops [4] = '{0, 0, 0, 0};
    logic [111:0] sb [4][$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tl_a_channel_queue #(
            .DEPTH (g == 1 ? 3 : 2),
            .FLOW  (g == 2 ? 1 : 0),
            .PIPE  (g == 3 ? 1 : 0)
        ) dut (
            .clock               (clk),
            .reset               (reset),
            .io_enq_valid        (enq_valid[g]),
            .io_enq_ready        (enq_ready[g]),
            .io_enq_bits_opcode  (opcode),
            .io_enq_bits_param   (param),
            .io_enq_bits_size    (size),
            .io_enq_bits_source  (source),
            .io_enq_bits_address (address),
            .io_enq_bits_data    (data),
            .io_enq_bits_corrupt (corrupt),
            .io_deq_valid        (deq_valid[g]),
            .io_deq_ready        (deq_ready[g]),
            .io_deq_bits_opcode  (deq_opcode[g]),
            .io_deq_bits_param   (deq_param[g]),
            .io_deq_bits_size    (deq_size[g]),
            .io_deq_bits_source  (deq_source[g]),
            .io_deq_bits_address (deq_address[g]),
            .io_deq_bits_data    (deq_data[g]),
            .io_deq_bits_corrupt (deq_corrupt[g]),
            .io_count            (count[g])
        );
    end

    task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (enq_valid[k] && enq_ready[k])
                    sb[k].push_back({opcode, param, size, source, address, data, corrupt});
                if (deq_valid[k] && deq_ready[k]) begin
                    check($sformatf("sb_nonempty%0d", k), 112'(sb[k].size() != 0), 112'(1));
                    if (sb[k].size() != 0)
                        check($sformatf("deq_beat%0d", k),
                              {deq_opcode[k], deq_param[k], deq_size[k], deq_source[k],
                               deq_address[k], deq_data[k], deq_corrupt[k]},
                              sb[k].pop_front());
                    pops[k]++;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [31:0] a, input logic [4:0] s, input logic c);
        address = a;
        source  = s;
        corrupt = c;
        data    = {a, ~a};
        opcode  = a[6:4];
        param   = s[2:0];
        size    = 4'd3;
        enq_valid[k] = 1'b1;
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [4:0] s, input logic c);
        int t = 0;
        drive(k, a, s, c);
        @(negedge clk);
        while (!enq_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("enq_timeout", 112'(t < 50), 112'(1));
        step();
        enq_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int t = 0;
        deq_ready[k] = 1'b1;
        @(negedge clk);
        while ((deq_valid[k] || count[k] != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 112'(t < 100), 112'(1));
        step();
        deq_ready[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int i, t;
        reset = 1'b1;
        {opcode, param, size, source, address, data, corrupt} = '0;
        for (int k = 0; k < 4; k++) begin
            enq_valid[k] = 1'b0;
            deq_ready[k] = 1'b0;
        end
        repeat (3) step();
        reset = 1'b0;

        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check("rst_deq_valid", 112'(deq_valid[k]), 112'(0));
                check("rst_enq_ready", 112'(enq_ready[k]), 112'(1));
                check("rst_count", 112'(count[k]), 112'(0));
            end
        end
        step();

        push(0, 32'h1000, 5'd1, 1'b0);
        push(0, 32'h1008, 5'd2, 1'b1);
        drive(0, 32'h1010, 5'd3, 1'b0);
        repeat (3) @(negedge clk);
        check("t2_stall_ready", 112'(enq_ready[0]), 112'(0));
        check("t2_full_count", 112'(count[0]), 112'(2));
        check("t2_head_addr", 112'(deq_address[0]), 112'(32'h1000));
        step();
        deq_ready[0] = 1'b1;
        push(0, 32'h1010, 5'd3, 1'b0);
        drain(0);
        check("t2_sb_empty", 112'(sb[0].size()), 112'(0));
        check("t2_pops", 112'(pops[0]), 112'(3));

        i = 0;
        t = 0;
        while (i < 10 && t < 300) begin
            drive(1, 32'h3000 + 32'(i * 8), 5'(i), 1'(i % 3 == 0));
            deq_ready[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (enq_ready[1]) i++;
            step();
            t++;
        end
        enq_valid[1] = 1'b0;
        check("t3_sent", 112'(i), 112'(10));
        drain(1);
        check("t3_pops", 112'(pops[1]), 112'(10));
        check("t3_sb_empty", 112'(sb[1].size()), 112'(0));

        drive(2, 32'h4000, 5'd7, 1'b0);
        deq_ready[2] = 1'b1;
        #1;
        check("t4_flow_valid", 112'(deq_valid[2]), 112'(1));
        check("t4_flow_source", 112'(deq_source[2]), 112'(7));
        check("t4_flow_count", 112'(count[2]), 112'(0));
        step();
        enq_valid[2] = 1'b0;
        deq_ready[2] = 1'b0;
        @(negedge clk);
        check("t4_after_count", 112'(count[2]), 112'(0));
        check("t4_after_valid", 112'(deq_valid[2]), 112'(0));
        check("t4_pops", 112'(pops[2]), 112'(1));
        step();

        push(3, 32'h5000, 5'd1, 1'b0);
        push(3, 32'h5008, 5'd2, 1'b1);
        @(negedge clk);
        check("t5_full_count", 112'(count[3]), 112'(2));
        check("t5_full_ready", 112'(enq_ready[3]), 112'(0));
        step();
        drive(3, 32'h5010, 5'd3, 1'b1);
        deq_ready[3] = 1'b1;
        @(negedge clk);
        check("t5_pipe_ready", 112'(enq_ready[3]), 112'(1));
        step();
        enq_valid[3] = 1'b0;
        deq_ready[3] = 1'b0;
        @(negedge clk);
        check("t5_count_kept", 112'(count[3]), 112'(2));
        check("t5_head_addr", 112'(deq_address[3]), 112'(32'h5008));
        step();
        drain(3);
        check("t5_sb_empty", 112'(sb[3].size()), 112'(0));

        push(0, 32'h6000, 5'd4, 1'b0);
        push(0, 32'h6008, 5'd6, 1'b1);
        @(negedge clk);
        check("t6_pre_count", 112'(count[0]), 112'(2));
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) sb[k].delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_deq_valid", 112'(deq_valid[0]), 112'(0));
        check("t6_count", 112'(count[0]), 112'(0));
        step();
        push(0, 32'h2000, 5'd5, 1'b1);
        @(negedge clk);
        check("t6_new_head", 112'(deq_address[0]), 112'(32'h2000));
        step();
        drain(0);
        check("t6_sb_empty", 112'(sb[0].size()), 112'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
